ysyx_22041207_lsu_axi: RTL and testbench

MEM-stage load/store unit that turns one pipeline memory request into one AXI4-Lite transaction on a 64-bit data bus. It drives the waitForAXI stall input of the hazard/bubble unit. It also returns load data, aligned and extended, to the MEM/WB path. It is the bus-initiator counterpart of the stall logic: it produces the wait condition that the bubble unit consumes.

---
 rtl/ysyx_22041207_lsu_axi.sv | 193 +++++++++++++++++++
 tb/tb_ysyx_22041207_lsu_axi.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_lsu_axi.sv
// MEM-stage load/store unit: one pipeline memory request -> one AXI4-Lite access on a 64-bit bus.
// Latency: 3 cycles to done with a zero-wait slave (1 on a size/alignment error); stalls the pipe via waitForAXI meanwhile.
module ysyx_22041207_lsu_axi #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [3:0]            me_readNum,
  input  logic [3:0]            me_writeNum,
  input  logic                  is_signed,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata_in,
  output logic                  waitForAXI,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata_out,
  output logic                  err,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t              r_state;
  logic [2:0]          r_off;
  logic [3:0]          r_size;
  logic                r_signed;
  logic                r_aw_done;
  logic                r_w_done;

  logic                w_is_load;
  logic                w_is_store;
  logic                w_access;
  logic [3:0]          w_size;
  logic                w_legal;
  logic [DATA_W/8-1:0] w_strb_base;
  logic [DATA_W/8-1:0] w_wstrb;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [DATA_W-1:0]   w_raw;
  logic [DATA_W-1:0]   w_ld_fmt;
  logic                w_aw_hs;
  logic                w_w_hs;

  // A load wins when both sizes are nonzero; the store half is dropped.
  assign w_is_load  = (me_readNum != 4'd0);
  assign w_is_store = !w_is_load && (me_writeNum != 4'd0);
  assign w_access   = req_valid && (w_is_load || w_is_store);
  assign w_size     = w_is_load ? me_readNum : me_writeNum;
  assign w_wdata_sh = wdata_in << {addr[2:0], 3'b000};
  assign w_wstrb    = w_strb_base << addr[2:0];
  assign w_aw_hs    = awvalid && awready;
  assign w_w_hs     = wvalid && wready;

  always_comb begin
    w_legal     = 1'b0;
    w_strb_base = '0;
    case (w_size)
      4'd1: begin w_legal = 1'b1;               w_strb_base = 8'h01; end
      4'd2: begin w_legal = !addr[0];           w_strb_base = 8'h03; end
      4'd4: begin w_legal = (addr[1:0] == 2'd0); w_strb_base = 8'h0F; end
      4'd8: begin w_legal = (addr[2:0] == 3'd0); w_strb_base = 8'hFF; end
      default: begin w_legal = 1'b0;            w_strb_base = '0;    end
    endcase
  end

  always_comb begin
    w_raw    = rdata >> {r_off, 3'b000};
    w_ld_fmt = w_raw;
    case (r_size)
      4'd1: w_ld_fmt = r_signed ? {{(DATA_W-8){w_raw[7]}}, w_raw[7:0]}
                                : {{(DATA_W-8){1'b0}}, w_raw[7:0]};
      4'd2: w_ld_fmt = r_signed ? {{(DATA_W-16){w_raw[15]}}, w_raw[15:0]}
                                : {{(DATA_W-16){1'b0}}, w_raw[15:0]};
      4'd4: w_ld_fmt = r_signed ? {{(DATA_W-32){w_raw[31]}}, w_raw[31:0]}
                                : {{(DATA_W-32){1'b0}}, w_raw[31:0]};
      default: w_ld_fmt = w_raw;
    endcase
  end

  // Gated by rst_n so the stall releases the moment reset asserts, even with req_valid still high.
  assign waitForAXI = rst_n && (((r_state == S_IDLE) && w_access) ||
                                (r_state == S_AR) || (r_state == S_R) ||
                                (r_state == S_AW_W) || (r_state == S_B));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_off     <= '0;
      r_size    <= '0;
      r_signed  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata_out <= '0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_off    <= addr[2:0];
            r_size   <= w_size;
            r_signed <= is_signed;
            if (!w_legal) begin
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (w_is_load) begin
              araddr  <= {addr[ADDR_W-1:3], 3'b000};
              arvalid <= 1'b1;
              r_state <= S_AR;
            end else begin
              awaddr    <= {addr[ADDR_W-1:3], 3'b000};
              wdata     <= w_wdata_sh;
              wstrb     <= w_wstrb;
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_AW_W;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rdata_out <= w_ld_fmt;
            err       <= (rresp != 2'b00);
            done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_AW_W: begin
          if (w_aw_hs) begin
            awvalid   <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            wvalid   <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            bready  <= 1'b1;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            err     <= (bresp != 2'b00);
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_lsu_axi.sv
// Scoreboard bench for the AXI4-Lite LSU: random requests, reactive slave, model-computed responses.
module tb_ysyx_22041207_lsu_axi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  me_readNum, me_writeNum;
  logic        is_signed;
  logic [31:0] addr;
  logic [63:0] wdata_in;
  logic        waitForAXI, done, err;
  logic [63:0] rdata_out;
  logic [31:0] araddr, awaddr;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        s_arready, m_arready, awready, wready, rvalid, bvalid;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  always #5 clk = ~clk;

  ysyx_22041207_lsu_axi dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .me_readNum(me_readNum), .me_writeNum(me_writeNum), .is_signed(is_signed),
    .addr(addr), .wdata_in(wdata_in), .waitForAXI(waitForAXI), .done(done),
    .rdata_out(rdata_out), .err(err),
    .araddr(araddr), .arvalid(arvalid), .arready(s_arready | m_arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          ld;
    logic [31:0] a;
    logic [63:0] wd;
    logic [7:0]  ws;
    logic [63:0] rd;
    logic [1:0]  resp;
    int          d0, d1, d2;
  } bus_t;

  typedef struct {
    logic [63:0] rout;
    logic        err;
  } res_t;

  bus_t        slave_q[$];
  res_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_rout = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event never happened or was unexpected", nm);
  endtask

  // ---------------- reactive AXI slave ----------------
  task automatic serve_read(input bus_t e);
    int n = 0;
    do begin @(negedge clk); n++; end while (!arvalid && n < 300);
    if (!arvalid) begin fail("ar_wait"); return; end
    chk("araddr", araddr, e.a);
    chk("no_aw_w_on_load", {awvalid, wvalid}, 0);
    repeat (e.d0) begin
      @(negedge clk);
      chk("ar_hold", {arvalid, araddr}, {1'b1, e.a});
    end
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0;
    chk("ar_drop", arvalid, 0);
    repeat (e.d1) @(negedge clk);
    rdata = e.rd; rresp = e.resp; rvalid = 1'b1;
    n = 0;
    while (!rready && n < 300) begin @(negedge clk); n++; end
    if (!rready) fail("rready_wait");
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'($urandom); rdata = {$urandom, $urandom};
  endtask

  task automatic serve_write(input bus_t e);
    int n = 0;
    do begin @(negedge clk); n++; end while (!awvalid && n < 300);
    if (!awvalid) begin fail("aw_wait"); return; end
    chk("awaddr", awaddr, e.a);
    chk("wdata", wdata, e.wd);
    chk("wstrb", wstrb, e.ws);
    chk("wvalid_with_awvalid", wvalid, 1);
    chk("no_ar_on_store", arvalid, 0);
    fork
      begin
        repeat (e.d0) begin
          @(negedge clk);
          chk("aw_hold", {awvalid, awaddr}, {1'b1, e.a});
          chk("no_b_before_aw", bready, 0);
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        chk("aw_drop", awvalid, 0);
      end
      begin
        repeat (e.d1) begin
          @(negedge clk);
          chk("w_hold", wvalid, 1);
          chk("w_payload", {wstrb, wdata[55:0]}, {e.ws, e.wd[55:0]});
          chk("no_b_before_w", bready, 0);
        end
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        chk("w_drop", wvalid, 0);
      end
    join
    chk("b_entered", bready, 1);
    repeat (e.d2) @(negedge clk);
    bresp = e.resp; bvalid = 1'b1;
    n = 0;
    while (!bready && n < 300) begin @(negedge clk); n++; end
    if (!bready) fail("bready_wait");
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'($urandom);
  endtask

  initial begin
    bus_t e;
    s_arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      wait (slave_q.size() != 0);
      e = slave_q.pop_front();
      if (e.ld) serve_read(e);
      else      serve_write(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        if (sb_q.size() == 0) fail("unexpected_done");
        else begin
          r = sb_q.pop_front();
          chk("rdata_out", rdata_out, r.rout);
          chk("err", err, r.err);
        end
      end
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic do_req(input logic [3:0] rn, input logic [3:0] wn, input logic sg,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input logic [1:0] resp, input int d0, input int d1, input int d2);
    bit ld, acc, legal, zl, got;
    int sz, off, n;
    logic [63:0] raw, mask, val;
    bus_t e;
    res_t r;
    ld  = (rn != 0);
    acc = (rn != 0) || (wn != 0);
    sz  = ld ? int'(rn) : int'(wn);
    off = int'(a % 8);
    legal = acc && (sz == 1 || sz == 2 || sz == 4 || sz == 8) && ((a % sz) == 0);
    r.err = 1'b1;
    if (legal) begin
      e.ld = ld; e.a = a & ~32'h7; e.wd = wd << (8 * off);
      e.ws = 8'(((1 << sz) - 1) << off);
      e.rd = rd; e.resp = resp; e.d0 = d0; e.d1 = d1; e.d2 = d2;
      slave_q.push_back(e);
      if (ld) begin
        raw  = rd >> (8 * off);
        mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        val  = raw & mask;
        if (sg && sz < 8 && raw[8 * sz - 1]) val = val | ~mask;
        model_rout = val;
      end
      r.err = (resp != 2'b00);
    end
    r.rout = model_rout;
    if (acc) sb_q.push_back(r);
    zl = (d0 == 0) && (d1 == 0) && (d2 == 0);

    @(negedge clk);
    req_valid = 1'b1; me_readNum = rn; me_writeNum = wn;
    is_signed = sg; addr = a; wdata_in = wd;
    #1;
    chk("stall_first_cycle", waitForAXI, acc);
    if (!acc) begin
      @(negedge clk);
      chk("no_access_quiet", {arvalid, awvalid, wvalid, done, waitForAXI}, 0);
      req_valid = 1'b0;
      return;
    end
    n = 0; got = 0;
    while (!got && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1;
      else begin
        chk("stall_held", waitForAXI, 1);
        if (n == 1) begin
          @(negedge clk);
          addr = $urandom; wdata_in = {$urandom, $urandom}; is_signed = 1'($urandom);
        end
      end
    end
    if (!got) fail("done_timeout");
    chk("stall_released_in_done", waitForAXI, 0);
    if (!legal) chk("no_bus_on_error", {arvalid, awvalid, wvalid}, 0);
    if (!legal || zl) chk("latency", n, legal ? 3 : 1);
    @(negedge clk);
    req_valid = 1'b0; me_readNum = 0; me_writeNum = 0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic reset_in_r();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; me_readNum = 8; me_writeNum = 0; is_signed = 0; addr = 32'h8000_0040;
    do begin @(negedge clk); n++; end while (!arvalid && n < 300);
    if (!arvalid) fail("rst_ar_wait");
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    chk("rst_pre_rready", rready, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_wait", waitForAXI, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rdata_out", rdata_out, 0);
    model_rout = '0;
    req_valid = 1'b0; me_readNum = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sizes[10] = '{1, 2, 4, 8, 1, 2, 4, 8, 3, 6};
    logic [63:0] rd;
    int kind, sz, off;
    logic [3:0] rn, wn;
    logic [31:0] a;
    logic [1:0] resp;
    bit zero;

    rst_n = 0; req_valid = 0; me_readNum = 0; me_writeNum = 0;
    is_signed = 0; addr = '0; wdata_in = '0; m_arready = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {arvalid, rready, awvalid, wvalid, bready, done, err, waitForAXI}, 0);
    chk("rst_rdata_out", rdata_out, 0);
    chk("rst_addrs", {araddr, awaddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    rst_n = 1;

    do_req(4, 0, 1, 32'h8000_0004, 64'h0, 64'hFFFF8000_00000000, 2'b00, 0, 0, 0);
    chk("lw_signed_value", rdata_out, 64'hFFFFFFFF_FFFF8000);
    chk("lw_araddr", araddr, 32'h8000_0000);

    rd = {$urandom, $urandom};
    rd[31:24] = 8'h9A;
    do_req(1, 0, 0, 32'h8000_0003, 64'h0, rd, 2'b00, 0, 1, 0);
    chk("lbu_value", rdata_out, 64'h9A);

    do_req(0, 2, 0, 32'h8000_0006, 64'h1234, 64'h0, 2'b00, 3, 0, 0);
    chk("sh_wdata", wdata, 64'h1234_0000_0000_0000);
    chk("sh_wstrb", wstrb, 8'hC0);

    do_req(0, 4, 0, 32'h8000_0002, 64'hDEAD_BEEF, 64'h0, 2'b00, 0, 0, 0);
    chk("sw_misaligned_err", err, 1);

    do_req(8, 0, 0, 32'h8000_0010, 64'h0, {$urandom, $urandom}, 2'b10, 1, 2, 0);
    reset_in_r();
    do_req(2, 0, 1, 32'h8000_0022, 64'h0, 64'h0000_8001_0000_0000 | {32'h0, $urandom}, 2'b00, 0, 0, 0);
    do_req(8, 8, 0, 32'h8000_0020, {$urandom, $urandom}, {$urandom, $urandom}, 2'b00, 0, 0, 0);
    do_req(0, 0, 0, 32'h8000_0000, 64'h0, 64'h0, 2'b00, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      sz   = sizes[$urandom_range(0, 9)];
      if (sz == 1 || sz == 2 || sz == 4 || sz == 8) begin
        if ($urandom_range(0, 4) == 0) off = $urandom_range(0, 7);
        else                            off = sz * $urandom_range(0, 8 / sz - 1);
      end else off = $urandom_range(0, 7);
      a  = 32'h8000_0000 + ($urandom_range(0, 255) << 3) + 32'(off);
      rn = 0; wn = 0;
      if (kind <= 3)      rn = 4'(sz);
      else if (kind <= 7) wn = 4'(sz);
      else if (kind == 8) begin rn = 4'(sz); wn = 4'($urandom_range(1, 8)); end
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      zero = ($urandom_range(0, 2) == 0);
      do_req(rn, wn, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom}, resp,
             zero ? 0 : $urandom_range(0, 3), zero ? 0 : $urandom_range(0, 3),
             zero ? 0 : $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("slave_queue_drained", slave_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
